// File: rtl/button_conditioner.sv
`timescale 1ns/1ps
// Two-channel push-button front end: 2-flop synchroniser, debounce FSM,
// registered level plus single-cycle press/release/long-press pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] button_raw,
  output logic [1:0] button_level,
  output logic [1:0] button_press,
  output logic [1:0] button_release,
  output logic [1:0] button_hold
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0] DB_ONE   = DW'(1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic          s1_q;
    logic          s2_q;
    state_e        state_q;
    logic [DW-1:0] db_cnt_q;
    logic [HW-1:0] hold_cnt_q;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          hold_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        s1_q       <= 1'b0;
        s2_q       <= 1'b0;
        state_q    <= RELEASED;
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        hold_q     <= 1'b0;
      end else begin
        s1_q      <= button_raw[ch];
        s2_q      <= s1_q;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        hold_q    <= 1'b0;
        case (state_q)
          RELEASED: begin
            if (s2_q) begin
              state_q  <= PRESS_WAIT;
              db_cnt_q <= DB_ONE;
            end
          end
          PRESS_WAIT: begin
            if (!s2_q) begin
              state_q  <= RELEASED;
              db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
              state_q    <= PRESSED;
              level_q    <= 1'b1;
              press_q    <= 1'b1;
              hold_cnt_q <= '0;
              db_cnt_q   <= '0;
            end else if (db_cnt_q != DB_MAX) begin
              db_cnt_q <= db_cnt_q + DB_ONE;
            end
          end
          PRESSED: begin
            // Saturating at HOLD_CYCLES guarantees one long-press pulse per press.
            if (hold_cnt_q != HOLD_MAX) begin
              hold_cnt_q <= hold_cnt_q + HOLD_ONE;
              if (hold_cnt_q == HOLD_LAST) hold_q <= 1'b1;
            end
            if (!s2_q) begin
              state_q  <= RELEASE_WAIT;
              db_cnt_q <= DB_ONE;
            end
          end
          RELEASE_WAIT: begin
            if (s2_q) begin
              state_q  <= PRESSED;
              db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
              state_q   <= RELEASED;
              level_q   <= 1'b0;
              release_q <= 1'b1;
              db_cnt_q  <= '0;
            end else if (db_cnt_q != DB_MAX) begin
              db_cnt_q <= db_cnt_q + DB_ONE;
            end
          end
          default: state_q <= RELEASED;
        endcase
      end
    end

    assign button_level[ch]   = level_q;
    assign button_press[ch]   = press_q;
    assign button_release[ch] = release_q;
    assign button_hold[ch]    = hold_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
// Directed plus random bench for button_conditioner, checked every cycle against
// a run-length reference model of the debounce and long-press rules.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 10;

  logic       clock;
  logic       reset_n;
  logic [1:0] button_raw;
  logic [1:0] button_level;
  logic [1:0] button_press;
  logic [1:0] button_release;
  logic [1:0] button_hold;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .button_raw    (button_raw),
    .button_level  (button_level),
    .button_press  (button_press),
    .button_release(button_release),
    .button_hold   (button_hold)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model: level flips after DEB consecutive synchronised samples
  // that disagree with it; long press counts cycles spent pressed with no
  // disagreeing samples pending
  logic [1:0] s1_m, s2_m, lvl_m, press_m, rel_m, hold_m;
  int         run_m  [2];
  int         held_m [2];

  task automatic model_reset();
    s1_m = '0; s2_m = '0; lvl_m = '0;
    press_m = '0; rel_m = '0; hold_m = '0;
    for (int c = 0; c < 2; c++) begin
      run_m[c]  = 0;
      held_m[c] = 0;
    end
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
      return;
    end
    press_m = '0; rel_m = '0; hold_m = '0;
    for (int c = 0; c < 2; c++) begin
      if (lvl_m[c] && run_m[c] == 0 && held_m[c] < HOLD) begin
        held_m[c]++;
        if (held_m[c] == HOLD) hold_m[c] = 1'b1;
      end
      if (s2_m[c] != lvl_m[c]) begin
        run_m[c]++;
        if (run_m[c] == DEB) begin
          lvl_m[c] = ~lvl_m[c];
          run_m[c] = 0;
          if (lvl_m[c]) begin
            press_m[c] = 1'b1;
            held_m[c]  = 0;
          end else begin
            rel_m[c] = 1'b1;
          end
        end
      end else begin
        run_m[c] = 0;
      end
    end
    s2_m = s1_m;
    s1_m = button_raw;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: advance n edges, comparing all outputs against the model after each
  task automatic step(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_edge();
      #1;
      check(tag, {button_level, button_press, button_release, button_hold},
            {lvl_m, press_m, rel_m, hold_m});
    end
  endtask

  initial begin
    model_reset();
    reset_n    = 1'b0;
    button_raw = 2'b00;
    step(3, "reset");
    check("reset_outputs", {button_level, button_press, button_release, button_hold}, 8'h00);
    #4 reset_n = 1'b1;

    // clean press on channel 0, then long press and release
    button_raw = 2'b01;
    step(5, "clean_wait");
    check("clean_no_early_press", button_press, 2'b00);
    step(1, "clean_edge");
    check("clean_press", button_press, 2'b01);
    check("clean_level", button_level, 2'b01);
    step(1, "clean_after");
    check("clean_press_one_cycle", button_press, 2'b00);
    step(8, "long_wait");
    check("long_no_early_hold", button_hold, 2'b00);
    step(1, "long_edge");
    check("long_hold", button_hold, 2'b01);
    step(1, "long_after");
    check("long_hold_one_cycle", button_hold, 2'b00);
    step(20, "long_no_repeat");
    button_raw = 2'b00;
    step(5, "rel_wait");
    check("rel_no_early", button_release, 2'b00);
    step(1, "rel_edge");
    check("rel_pulse", button_release, 2'b01);
    check("rel_level", button_level, 2'b00);
    step(6, "rel_idle");

    // release glitch while pressed: hold count pauses for the excursion
    button_raw = 2'b01;
    step(6, "glitch_press");
    check("glitch_press", button_press, 2'b01);
    step(3, "glitch_held");
    button_raw = 2'b00;
    step(2, "glitch_low");
    button_raw = 2'b01;
    step(6, "glitch_recover");
    check("glitch_level", button_level, 2'b01);
    check("glitch_hold_delayed", button_hold, 2'b00);
    step(1, "glitch_hold_edge");
    check("glitch_hold", button_hold, 2'b01);
    button_raw = 2'b00;
    step(10, "glitch_release");

    // bounce: 3 high samples, 1 low, then steady high
    button_raw = 2'b01;
    step(3, "bounce_high");
    button_raw = 2'b00;
    step(1, "bounce_low");
    button_raw = 2'b01;
    step(5, "bounce_wait");
    check("bounce_no_early", button_press, 2'b00);
    step(1, "bounce_edge");
    check("bounce_press", button_press, 2'b01);
    button_raw = 2'b00;
    step(10, "bounce_release");

    // simultaneous press, then reset while pressed
    button_raw = 2'b11;
    step(6, "simul_press");
    check("simul_press", button_press, 2'b11);
    step(3, "simul_held");
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid_outputs", {button_level, button_press, button_release, button_hold}, 8'h00);
    model_reset();
    step(2, "reset_mid_hold");
    #4 reset_n = 1'b1;
    step(5, "repress_wait");
    check("repress_no_early", button_press, 2'b00);
    step(1, "repress_edge");
    check("repress_press", button_press, 2'b11);
    button_raw = 2'b00;
    step(10, "repress_release");

    // randomized bouncing on both channels
    for (int s = 0; s < 80; s++) begin
      button_raw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) step($urandom_range(8, 30), "random_long");
      else step($urandom_range(1, 6), "random_short");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
